mem_arbiter: RTL and testbench

- Parametrised N-channel arbiter sharing one Memory port among several masters (processors, DMA, debug) over the existing Enable/Rd/Wr/Length/Rdy handshake.
- Sits between requesters and Memory in the top-level Computer.
- Round-robin fairness, request latching, malformed-request rejection and a per-access timeout with error reporting.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_rr_picker.sv | 44 ++++
 rtl/mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the memory arbiter and later
// interconnect blocks.
//   arb_state_e : arbiter state encoding (IDLE / BUSY / RESP)
//   LEN_BYTE/LEN_WORD : encodings of the Length handshake field
//   CNT_W       : width of the per-access timeout counter
//   idx_width() : width of a channel index for an N-channel block (>= 1)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic LEN_BYTE = 1'b0;
  localparam logic LEN_WORD = 1'b1;

  localparam int CNT_W = 16;

  // A single channel still gets a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_i   : request vector, one bit per channel
//   ptr_i   : channel with the highest priority this round
//   valid_o : at least one request is present
//   index_o : first requesting channel at or after ptr_i, wrapping N-1 -> 0
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] index_o
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;

  // Scan N candidates starting at ptr_i; the first hit wins.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so ptr+k never overflows before the modulo wrap.
      sum_s = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum_s >= (IW+1)'(N)) begin
        cand_s = IW'(sum_s - (IW+1)'(N));
      end else begin
        cand_s = sum_s[IW-1:0];
      end
      if (!valid_o && req_i[cand_s]) begin
        valid_o = 1'b1;
        index_o = cand_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel round-robin arbiter in front of one Memory port.
// Requester side (per channel i):
//   reqEnable/reqRd/reqWr/reqLength[i], reqAddr[i*AW +: AW],
//   reqWrData[i*DW +: DW]  -> request, held until reqRdy[i]
//   reqRdy[i], reqErr[i]   <- one-cycle completion pulse and error flag
//   reqRdData              <- read data broadcast, valid with reqRdy
//   grant                  <- one-hot owner while BUSY/RESP
// Memory side:
//   memEnable/memRd/memWr/memLength/memAddr/memWrData -> access
//   memRdy/memRdData                                  <- completion
// Clk rising edge, Reset asynchronous active-low.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N       = 2,
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N-1:0]    reqEnable,
  input  logic [N-1:0]    reqRd,
  input  logic [N-1:0]    reqWr,
  input  logic [N-1:0]    reqLength,
  input  logic [N*AW-1:0] reqAddr,
  input  logic [N*DW-1:0] reqWrData,
  output logic [N-1:0]    reqRdy,
  output logic [N-1:0]    reqErr,
  output logic [DW-1:0]   reqRdData,
  output logic [N-1:0]    grant,
  output logic [AW-1:0]   memAddr,
  output logic            memLength,
  output logic            memRd,
  output logic            memWr,
  output logic            memEnable,
  output logic [DW-1:0]   memWrData,
  input  logic            memRdy,
  input  logic [DW-1:0]   memRdData
);

  localparam int IW = idx_width(N);
  // Counter value of the last BUSY cycle allowed before a timeout.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  arb_state_e       state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_rd_q;
  logic             memEnable_q;
  logic             memRd_q;
  logic             memWr_q;
  logic             memLength_q;
  logic [AW-1:0]    memAddr_q;
  logic [DW-1:0]    memWrData_q;
  logic [N-1:0]     reqRdy_q;
  logic [N-1:0]     reqErr_q;
  logic [DW-1:0]    reqRdData_q;
  logic [N-1:0]     grant_q;

  logic             win_valid_s;
  logic [IW-1:0]    win_idx_s;
  logic [N-1:0]     win_onehot_s;
  logic             win_rd_s;
  logic             win_wr_s;
  logic             win_len_s;
  logic [AW-1:0]    win_addr_s;
  logic [DW-1:0]    win_wdata_s;
  logic             malformed_s;
  logic             timeout_hit_s;
  logic [IW:0]      ptr_sum_s;
  logic [IW-1:0]    ptr_next_s;

  rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .req_i   (reqEnable),
    .ptr_i   (ptr_q),
    .valid_o (win_valid_s),
    .index_o (win_idx_s)
  );

  // Route the winning channel's request fields to the latch inputs.
  always_comb begin
    win_onehot_s = '0;
    win_rd_s     = 1'b0;
    win_wr_s     = 1'b0;
    win_len_s    = LEN_BYTE;
    win_addr_s   = '0;
    win_wdata_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx_s == IW'(i)) begin
        win_onehot_s[i] = 1'b1;
        win_rd_s        = reqRd[i];
        win_wr_s        = reqWr[i];
        win_len_s       = reqLength[i];
        win_addr_s      = reqAddr[i*AW +: AW];
        win_wdata_s     = reqWrData[i*DW +: DW];
      end else begin
        win_onehot_s[i] = 1'b0;
      end
    end
  end

  // Rd==Wr is neither a read nor a write: answer with an error, never touch Memory.
  assign malformed_s   = (win_rd_s == win_wr_s);
  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Next round starts just after the channel that was served.
  always_comb begin
    ptr_sum_s = {1'b0, owner_q} + (IW+1)'(1);
    if (ptr_sum_s >= (IW+1)'(N)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = ptr_sum_s[IW-1:0];
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      op_rd_q     <= 1'b0;
      memEnable_q <= 1'b0;
      memRd_q     <= 1'b0;
      memWr_q     <= 1'b0;
      memLength_q <= LEN_BYTE;
      memAddr_q   <= '0;
      memWrData_q <= '0;
      reqRdy_q    <= '0;
      reqErr_q    <= '0;
      reqRdData_q <= '0;
      grant_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid_s) begin
            owner_q     <= win_idx_s;
            grant_q     <= win_onehot_s;
            op_rd_q     <= win_rd_s;
            memAddr_q   <= win_addr_s;
            memLength_q <= win_len_s;
            memWrData_q <= win_wdata_s;
            cnt_q       <= '0;
            if (malformed_s) begin
              state_q  <= ST_RESP;
              reqRdy_q <= win_onehot_s;
              reqErr_q <= win_onehot_s;
            end else begin
              state_q     <= ST_BUSY;
              memEnable_q <= 1'b1;
              memRd_q     <= win_rd_s;
              memWr_q     <= win_wr_s;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // memRdy is checked first so a completion in the timeout cycle still succeeds.
          if (memRdy) begin
            if (op_rd_q) begin
              reqRdData_q <= memRdData;
            end else begin
              reqRdData_q <= reqRdData_q;
            end
            state_q     <= ST_RESP;
            memEnable_q <= 1'b0;
            memRd_q     <= 1'b0;
            memWr_q     <= 1'b0;
            reqRdy_q    <= grant_q;
            reqErr_q    <= '0;
          end else if (timeout_hit_s) begin
            state_q     <= ST_RESP;
            memEnable_q <= 1'b0;
            memRd_q     <= 1'b0;
            memWr_q     <= 1'b0;
            reqRdy_q    <= grant_q;
            reqErr_q    <= grant_q;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_RESP: begin
          state_q  <= ST_IDLE;
          reqRdy_q <= '0;
          reqErr_q <= '0;
          grant_q  <= '0;
          cnt_q    <= '0;
          ptr_q    <= ptr_next_s;
        end
        default: begin
          state_q     <= ST_IDLE;
          memEnable_q <= 1'b0;
          memRd_q     <= 1'b0;
          memWr_q     <= 1'b0;
          reqRdy_q    <= '0;
          reqErr_q    <= '0;
          grant_q     <= '0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign memEnable = memEnable_q;
  assign memRd     = memRd_q;
  assign memWr     = memWr_q;
  assign memLength = memLength_q;
  assign memAddr   = memAddr_q;
  assign memWrData = memWrData_q;
  assign reqRdy    = reqRdy_q;
  assign reqErr    = reqErr_q;
  assign reqRdData = reqRdData_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;

  logic            Clk;
  logic            Reset;
  logic [N-1:0]    reqEnable, reqRd, reqWr, reqLength;
  logic [N*AW-1:0] reqAddr;
  logic [N*DW-1:0] reqWrData;
  logic [N-1:0]    reqRdy, reqErr, grant;
  logic [DW-1:0]   reqRdData;
  logic [AW-1:0]   memAddr;
  logic            memLength, memRd, memWr, memEnable;
  logic [DW-1:0]   memWrData;
  logic            memRdy;
  logic [DW-1:0]   memRdData;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .reqEnable(reqEnable), .reqRd(reqRd), .reqWr(reqWr), .reqLength(reqLength),
    .reqAddr(reqAddr), .reqWrData(reqWrData),
    .reqRdy(reqRdy), .reqErr(reqErr), .reqRdData(reqRdData), .grant(grant),
    .memAddr(memAddr), .memLength(memLength), .memRd(memRd), .memWr(memWr),
    .memEnable(memEnable), .memWrData(memWrData),
    .memRdy(memRdy), .memRdData(memRdData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- Memory model with programmable latency ----------------
  logic [31:0] mem_store [logic [23:0]];
  int mem_lat = 1;   // 0 = never answer
  int mem_cnt = 0;

  function automatic logic [31:0] mem_read(input logic [23:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {8'hA5, a};
  endfunction

  always @(negedge Clk or negedge Reset) begin
    if (!Reset) begin
      mem_cnt   = 0;
      memRdy    = 1'b0;
      memRdData = 32'h0;
    end else if (memEnable) begin
      mem_cnt = mem_cnt + 1;
      if (mem_lat != 0 && mem_cnt == mem_lat) begin
        memRdy = 1'b1;
        if (memRd) memRdData = mem_read(memAddr);
        else memRdData = 32'h0BADF00D;
        if (memWr) mem_store[memAddr] = memWrData;
      end else begin
        memRdy    = 1'b0;
        memRdData = 32'h0BADF00D;
      end
    end else begin
      mem_cnt = 0;
      memRdy  = 1'b0;
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct {
    int          ch;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [3:0]  mon_oh;
  logic [31:0] exp_rdata = 32'h0;

  task automatic push_read(input int ch, input logic [31:0] d);
    sb_q.push_back('{ch: ch, err: 1'b0, rdata: d});
    exp_rdata = d;
  endtask

  task automatic push_write(input int ch);
    sb_q.push_back('{ch: ch, err: 1'b0, rdata: exp_rdata});
  endtask

  task automatic push_err(input int ch);
    sb_q.push_back('{ch: ch, err: 1'b1, rdata: exp_rdata});
  endtask

  // Completion monitor: each reqRdy pulse consumes one expected entry.
  always @(negedge Clk) begin
    if (Reset && (reqRdy !== 4'b0000)) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_unexpected: reqRdy=%b with nothing expected", reqRdy);
      end else begin
        mon_e  = sb_q.pop_front();
        mon_oh = 4'b0001 << mon_e.ch;
        tests_run++;
        if (reqRdy !== mon_oh) begin
          tests_failed++;
          $display("FAIL sb_owner: reqRdy=%b expected %b", reqRdy, mon_oh);
        end
        tests_run++;
        if (reqErr !== (mon_e.err ? mon_oh : 4'b0000)) begin
          tests_failed++;
          $display("FAIL sb_err: reqErr=%b expected %b", reqErr, mon_e.err ? mon_oh : 4'b0000);
        end
        tests_run++;
        if (reqRdData !== mon_e.rdata) begin
          tests_failed++;
          $display("FAIL sb_rdata: reqRdData=%h expected %h (ch%0d)", reqRdData, mon_e.rdata, mon_e.ch);
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic rd, input logic wr,
                        input logic [23:0] addr, input logic [31:0] wd);
    reqRd[ch]              = rd;
    reqWr[ch]              = wr;
    reqLength[ch]          = 1'b1;
    reqAddr[ch*AW +: AW]   = addr;
    reqWrData[ch*DW +: DW] = wd;
    reqEnable[ch]          = 1'b1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  // Wait for the channel's completion, then drop its request in the RESP cycle.
  task automatic wait_rdy(input int ch);
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (reqRdy[ch]) begin
        got = 1'b1;
        reqEnable[ch] = 1'b0;
        break;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL wait_rdy_ch%0d: no reqRdy within 100 cycles, expected a completion", ch);
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    #2;
    tests_run++;
    if ({memEnable, memRd, memWr, memLength} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_memctl: got %b expected 0000", {memEnable, memRd, memWr, memLength});
    end
    tests_run++;
    if ({reqRdy, reqErr, grant} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_req: got %h expected 000", {reqRdy, reqErr, grant});
    end
    tests_run++;
    if ({memAddr, memWrData, reqRdData} !== 88'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 0", {memAddr, memWrData, reqRdData});
    end
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_single_read();
    int en = 0, bad = 0, rdy_at = -1;
    tick();
    mem_store[24'h000100] = 32'hDEADBEEF;
    mem_lat = 3;
    push_read(2, 32'hDEADBEEF);
    set_ch(2, 1'b1, 1'b0, 24'h000100, 32'h0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (memEnable) begin
        en++;
        if (memAddr !== 24'h000100 || memRd !== 1'b1 || memWr !== 1'b0 ||
            memLength !== 1'b1 || grant !== 4'b0100) bad++;
      end
      if (reqRdy[2]) begin
        rdy_at = i;
        if (grant !== 4'b0100) bad++;
        reqEnable[2] = 1'b0;
        break;
      end
    end
    tests_run++;
    if (en != 3) begin
      tests_failed++;
      $display("FAIL read_en_cycles: got %0d expected 3", en);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL read_bus_fields: %0d bad cycles, expected 0", bad);
    end
    tests_run++;
    if (rdy_at != 3) begin
      tests_failed++;
      $display("FAIL read_latency: reqRdy at tick %0d expected 3", rdy_at);
    end
    tick();
    tests_run++;
    if ({reqRdy, grant} !== 8'h00) begin
      tests_failed++;
      $display("FAIL read_pulse_end: reqRdy/grant=%h expected 00", {reqRdy, grant});
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int order[9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
    do_reset();
    mem_lat = 1;
    foreach (order[k]) push_read(order[k], {8'hA5, 24'h001000 + 24'(order[k])});
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b0, 24'h001000 + 24'(c), 32'h0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (reqRdy !== 4'b0000) begin
        n++;
        if (n == 5) reqEnable = 4'b1010;
        if (n == 9) begin
          reqEnable = 4'b0000;
          break;
        end
      end
    end
    tests_run++;
    if (n != 9) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d completions expected 9", n);
    end
  endtask

  task automatic test_timeout();
    int en = 0;
    bit got = 1'b0;
    tick();
    mem_lat = 0;
    push_err(1);
    push_read(2, {8'hA5, 24'h002002});
    set_ch(1, 1'b0, 1'b1, 24'h0000FF, 32'h12345678);
    set_ch(2, 1'b1, 1'b0, 24'h002002, 32'h0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (memEnable) en++;
      if (reqRdy[1]) begin
        got = 1'b1;
        tests_run++;
        if (reqErr[1] !== 1'b1) begin
          tests_failed++;
          $display("FAIL to_err: reqErr[1]=%b expected 1", reqErr[1]);
        end
        reqEnable[1] = 1'b0;
        mem_lat = 2;
        break;
      end
    end
    tests_run++;
    if (!got || en != 16) begin
      tests_failed++;
      $display("FAIL to_en_cycles: got %0d (done=%0d) expected 16", en, got);
    end
    tick();
    tick();
    tests_run++;
    if (grant !== 4'b0100) begin
      tests_failed++;
      $display("FAIL to_next_grant: grant=%b expected 0100", grant);
    end
    wait_rdy(2);
  endtask

  task automatic test_malformed();
    tick();
    mem_lat = 1;
    push_err(3);
    push_read(0, {8'hA5, 24'h002000});
    push_read(3, {8'hA5, 24'h002003});
    set_ch(3, 1'b1, 1'b1, 24'h000333, 32'h0);
    tick();
    tests_run++;
    if ({reqRdy[3], reqErr[3], memEnable} !== 3'b110) begin
      tests_failed++;
      $display("FAIL malformed_resp: rdy/err/memEnable=%b expected 110", {reqRdy[3], reqErr[3], memEnable});
    end
    set_ch(3, 1'b1, 1'b0, 24'h002003, 32'h0);
    set_ch(0, 1'b1, 1'b0, 24'h002000, 32'h0);
    tick();
    tick();
    tests_run++;
    if (grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL malformed_ptr: grant=%b expected 0001", grant);
    end
    wait_rdy(0);
    wait_rdy(3);
  endtask

  task automatic test_reset_mid();
    tick();
    mem_lat = 1;
    push_read(2, {8'hA5, 24'h002002});
    set_ch(2, 1'b1, 1'b0, 24'h002002, 32'h0);
    wait_rdy(2);
    tick();
    mem_lat = 5;
    set_ch(0, 1'b1, 1'b0, 24'h000100, 32'h0);
    tick();
    tests_run++;
    if ({memEnable, grant} !== 5'b10001) begin
      tests_failed++;
      $display("FAIL mid_busy: memEnable/grant=%b expected 10001", {memEnable, grant});
    end
    tick();
    Reset = 1'b0;
    #1;
    tests_run++;
    if ({memEnable, memRd, memWr, memLength, reqRdy, reqErr, grant} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_async_ctl: got %h expected 0000", {memEnable, memRd, memWr, memLength, reqRdy, reqErr, grant});
    end
    tests_run++;
    if ({memAddr, reqRdData} !== 56'h0) begin
      tests_failed++;
      $display("FAIL mid_async_data: got %h expected 0", {memAddr, reqRdData});
    end
    tick();
    tick();
    set_ch(3, 1'b1, 1'b0, 24'h002003, 32'h0);
    push_read(0, 32'hDEADBEEF);
    push_read(3, {8'hA5, 24'h002003});
    Reset = 1'b1;
    tick();
    tests_run++;
    if (grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL mid_first_grant: grant=%b expected 0001", grant);
    end
    wait_rdy(0);
    wait_rdy(3);
  endtask

  task automatic test_late_rdy();
    int en = 0;
    bit got = 1'b0;
    tick();
    mem_lat = 2;
    push_write(1);
    set_ch(1, 1'b0, 1'b1, 24'h000300, 32'h55AA55AA);
    wait_rdy(1);
    tick();
    mem_lat = 16;
    push_read(2, 32'h55AA55AA);
    set_ch(2, 1'b1, 1'b0, 24'h000300, 32'h0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (memEnable) en++;
      if (reqRdy[2]) begin
        got = 1'b1;
        reqEnable[2] = 1'b0;
        break;
      end
    end
    tests_run++;
    if (!got || en != 16) begin
      tests_failed++;
      $display("FAIL late_rdy_cycles: got %0d (done=%0d) expected 16", en, got);
    end
    tick();
  endtask

  initial begin
    Reset     = 1'b0;
    reqEnable = '0;
    reqRd     = '0;
    reqWr     = '0;
    reqLength = '0;
    reqAddr   = '0;
    reqWrData = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_malformed();
    test_reset_mid();
    test_late_rdy();
    tick();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: %0d completions outstanding, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
